// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory load/store requests over a req/ack
// handshake, stalls upstream while an access is outstanding, and fills MEM/WB.
module mem_stage_ctrl #(
   parameter int XLEN     = 64,
   parameter int MAX_WAIT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_result,
   input  logic [XLEN-1:0] ex_writedata,
   input  logic [4:0]      ex_rd,
   input  logic            ex_memread,
   input  logic            ex_memwrite,
   input  logic            ex_memtoreg,
   input  logic            ex_regwrite,
   output logic            mem_stall,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_aluresult,
   output logic [XLEN-1:0] wb_readdata,
   output logic [4:0]      wb_rd,
   output logic            wb_memtoreg,
   output logic            wb_regwrite,
   output logic            mem_timeout
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

   state_t          state_q, state_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic            we_q, we_d;
   logic [4:0]      rd_q, rd_d;
   logic            memtoreg_q, memtoreg_d;
   logic            regwrite_q, regwrite_d;

   logic            wb_valid_q, wb_valid_d;
   logic [XLEN-1:0] wb_aluresult_q, wb_aluresult_d;
   logic [XLEN-1:0] wb_readdata_q, wb_readdata_d;
   logic [4:0]      wb_rd_q, wb_rd_d;
   logic            wb_memtoreg_q, wb_memtoreg_d;
   logic            wb_regwrite_q, wb_regwrite_d;
   logic            timeout_q, timeout_d;

   logic            memop;
   logic            busy_ack;
   logic            busy_expire;

   assign memop       = ex_valid & (ex_memread | ex_memwrite);
   assign busy_ack    = (state_q == BUSY) & dmem_ack;
   assign busy_expire = (state_q == BUSY) & ~dmem_ack & (cnt_q == LAST_WAIT);

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      we_d           = we_q;
      rd_d           = rd_q;
      memtoreg_d     = memtoreg_q;
      regwrite_d     = regwrite_q;
      timeout_d      = timeout_q;
      // MEM/WB takes a bubble unless an entry retires this cycle.
      wb_valid_d     = 1'b0;
      wb_aluresult_d = '0;
      wb_readdata_d  = '0;
      wb_rd_d        = '0;
      wb_memtoreg_d  = 1'b0;
      wb_regwrite_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (memop) begin
               addr_d     = ex_result;
               wdata_d    = ex_writedata;
               we_d       = ex_memwrite;
               rd_d       = ex_rd;
               memtoreg_d = ex_memtoreg;
               regwrite_d = ex_regwrite;
               cnt_d      = '0;
               state_d    = BUSY;
            end else if (ex_valid) begin
               wb_valid_d     = 1'b1;
               wb_aluresult_d = ex_result;
               wb_rd_d        = ex_rd;
               wb_memtoreg_d  = ex_memtoreg;
               wb_regwrite_d  = ex_regwrite;
            end
         end
         BUSY: begin
            if (dmem_ack) begin
               wb_valid_d     = 1'b1;
               wb_aluresult_d = addr_q;
               wb_readdata_d  = we_q ? '0 : dmem_rdata;
               wb_rd_d        = rd_q;
               wb_memtoreg_d  = memtoreg_q;
               wb_regwrite_d  = regwrite_q;
               state_d        = IDLE;
            end else if (cnt_q == LAST_WAIT) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         we_q           <= 1'b0;
         rd_q           <= '0;
         memtoreg_q     <= 1'b0;
         regwrite_q     <= 1'b0;
         timeout_q      <= 1'b0;
         wb_valid_q     <= 1'b0;
         wb_aluresult_q <= '0;
         wb_readdata_q  <= '0;
         wb_rd_q        <= '0;
         wb_memtoreg_q  <= 1'b0;
         wb_regwrite_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         we_q           <= we_d;
         rd_q           <= rd_d;
         memtoreg_q     <= memtoreg_d;
         regwrite_q     <= regwrite_d;
         timeout_q      <= timeout_d;
         wb_valid_q     <= wb_valid_d;
         wb_aluresult_q <= wb_aluresult_d;
         wb_readdata_q  <= wb_readdata_d;
         wb_rd_q        <= wb_rd_d;
         wb_memtoreg_q  <= wb_memtoreg_d;
         wb_regwrite_q  <= wb_regwrite_d;
      end
   end

   // The ack and expiry cycles release the stall so EX/MEM advances at that edge.
   assign mem_stall = reset & (((state_q == IDLE) & memop) |
                               ((state_q == BUSY) & ~busy_ack & ~busy_expire));
   assign dmem_req  = reset & (state_q == BUSY);

   assign dmem_we      = we_q;
   assign dmem_addr    = addr_q;
   assign dmem_wdata   = wdata_q;
   assign wb_valid     = wb_valid_q;
   assign wb_aluresult = wb_aluresult_q;
   assign wb_readdata  = wb_readdata_q;
   assign wb_rd        = wb_rd_q;
   assign wb_memtoreg  = wb_memtoreg_q;
   assign wb_regwrite  = wb_regwrite_q;
   assign mem_timeout  = timeout_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomised bench for mem_stage_ctrl: each EX/MEM entry is run as one
// transaction and its MEM/WB and handshake behaviour predicted from its ack delay.
module tb_mem_stage_ctrl;

   localparam int XLEN = 64;
   localparam int MW   = 4;

   logic            clk;
   logic            reset;
   logic            ex_valid;
   logic [XLEN-1:0] ex_result;
   logic [XLEN-1:0] ex_writedata;
   logic [4:0]      ex_rd;
   logic            ex_memread;
   logic            ex_memwrite;
   logic            ex_memtoreg;
   logic            ex_regwrite;
   logic            mem_stall;
   logic            dmem_req;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic            dmem_ack;
   logic [XLEN-1:0] dmem_rdata;
   logic            wb_valid;
   logic [XLEN-1:0] wb_aluresult;
   logic [XLEN-1:0] wb_readdata;
   logic [4:0]      wb_rd;
   logic            wb_memtoreg;
   logic            wb_regwrite;
   logic            mem_timeout;

   int   n_cmp = 0;
   int   n_err = 0;
   int   n_txn = 0;
   logic exp_timeout = 1'b0;

   mem_stage_ctrl #(.XLEN(XLEN), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_result(ex_result), .ex_writedata(ex_writedata),
      .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
      .mem_stall(mem_stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_aluresult(wb_aluresult), .wb_readdata(wb_readdata),
      .wb_rd(wb_rd), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
      .mem_timeout(mem_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_wb(input logic v, input logic [63:0] alu, input logic [63:0] rdat,
                           input logic [4:0] rd, input logic mtr, input logic rw);
      check("wb_valid", 64'(wb_valid), 64'(v));
      check("wb_aluresult", wb_aluresult, v ? alu : 64'd0);
      check("wb_readdata", wb_readdata, v ? rdat : 64'd0);
      check("wb_rd", 64'(wb_rd), v ? 64'(rd) : 64'd0);
      check("wb_memtoreg", 64'(wb_memtoreg), v ? 64'(mtr) : 64'd0);
      check("wb_regwrite", 64'(wb_regwrite), v ? 64'(rw) : 64'd0);
   endtask

   task automatic scramble_ex();
      ex_valid     = 1'($urandom_range(0, 1));
      ex_result    = {$urandom, $urandom};
      ex_writedata = {$urandom, $urandom};
      ex_rd        = 5'($urandom);
      ex_memread   = 1'($urandom_range(0, 1));
      ex_memwrite  = 1'($urandom_range(0, 1));
      ex_memtoreg  = 1'($urandom_range(0, 1));
      ex_regwrite  = 1'($urandom_range(0, 1));
   endtask

   // d = BUSY cycles without ack before the ack; d >= MW means never acked.
   task automatic run_entry(input logic v, input logic mr, input logic mw, input logic mtr,
                            input logic rw, input logic [63:0] res, input logic [63:0] wd,
                            input logic [4:0] rd, input int d);
      logic        memop;
      logic        timed;
      logic [63:0] rdat;
      int          last;
      memop = v & (mr | mw);
      timed = (d >= MW);
      last  = timed ? MW - 1 : d;
      n_txn++;
      $display("txn %0d: valid=%0d rd_op=%0d wr_op=%0d addr=%h wdata=%h rd=%0d ack_delay=%0d",
               n_txn, v, mr, mw, res, wd, rd, d);
      ex_valid = v; ex_result = res; ex_writedata = wd; ex_rd = rd;
      ex_memread = mr; ex_memwrite = mw; ex_memtoreg = mtr; ex_regwrite = rw;
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      check("stall_idle", 64'(mem_stall), 64'(memop));
      check("req_idle", 64'(dmem_req), 64'd0);
      @(posedge clk); #1;
      check("timeout", 64'(mem_timeout), 64'(exp_timeout));
      if (!memop) begin
         check_wb(v, res, 64'd0, rd, mtr, rw);
      end else begin
         check_wb(1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
         for (int k = 0; k <= last; k++) begin
            scramble_ex();
            dmem_ack   = !timed && (k == d);
            rdat       = {$urandom, $urandom};
            dmem_rdata = rdat;
            @(negedge clk);
            check("req_busy", 64'(dmem_req), 64'd1);
            check("addr_busy", dmem_addr, res);
            check("wdata_busy", dmem_wdata, wd);
            check("we_busy", 64'(dmem_we), 64'(mw));
            check("stall_busy", 64'(mem_stall), 64'(k != last));
            @(posedge clk); #1;
            if (k == last && !timed)
               check_wb(1'b1, res, mw ? 64'd0 : rdat, rd, mtr, rw);
            else
               check_wb(1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
            if (k == last && timed) exp_timeout = 1'b1;
            check("timeout", 64'(mem_timeout), 64'(exp_timeout));
         end
         dmem_ack = 1'b0;
      end
   endtask

   task automatic reset_cycles(input int n);
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         scramble_ex();
         ex_valid = 1'b1; ex_memread = 1'b1;
         dmem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("req_rst", 64'(dmem_req), 64'd0);
         check("stall_rst", 64'(mem_stall), 64'd0);
         @(posedge clk); #1;
         check_wb(1'b0, 64'd0, 64'd0, 5'd0, 1'b0, 1'b0);
         check("addr_rst", dmem_addr, 64'd0);
         check("wdata_rst", dmem_wdata, 64'd0);
         check("we_rst", 64'(dmem_we), 64'd0);
         check("timeout_rst", 64'(mem_timeout), 64'd0);
      end
      exp_timeout = 1'b0;
      reset = 1'b1;
      ex_valid = 1'b0;
      dmem_ack = 1'b0;
   endtask

   initial begin
      int kind;
      logic mr, mw;
      reset = 1'b0;
      ex_valid = 0; ex_result = 0; ex_writedata = 0; ex_rd = 0;
      ex_memread = 0; ex_memwrite = 0; ex_memtoreg = 0; ex_regwrite = 0;
      dmem_ack = 0; dmem_rdata = 0;
      @(posedge clk); #1;
      reset_cycles(2);

      run_entry(1, 0, 0, 0, 1, 64'h1234, 64'd0, 5'd5, 0);
      run_entry(1, 1, 0, 1, 1, 64'h80, 64'd0, 5'd7, 3);
      run_entry(1, 0, 1, 0, 0, 64'h40, 64'hA5A5, 5'd3, 0);
      run_entry(1, 0, 0, 0, 1, 64'h55AA, 64'd0, 5'd9, 0);
      run_entry(1, 1, 0, 1, 1, 64'h200, 64'd0, 5'd11, 100);
      run_entry(1, 0, 0, 1, 1, 64'h777, 64'd0, 5'd12, 0);
      run_entry(1, 1, 1, 1, 1, 64'h300, 64'hBEEF, 5'd13, 1);
      run_entry(0, 1, 0, 1, 1, 64'h310, 64'd0, 5'd14, 0);

      // Reset two cycles while an access to 0x100 is outstanding.
      ex_valid = 1; ex_memread = 1; ex_memwrite = 0; ex_result = 64'h100; ex_rd = 5'd2;
      dmem_ack = 1'b0;
      @(posedge clk); #1;
      scramble_ex();
      @(negedge clk);
      check("req_pre_rst", 64'(dmem_req), 64'd1);
      check("addr_pre_rst", dmem_addr, 64'h100);
      @(posedge clk); #1;
      reset_cycles(2);
      run_entry(1, 0, 0, 0, 1, 64'hABCD, 64'd0, 5'd6, 0);

      for (int t = 0; t < 80; t++) begin
         kind = $urandom_range(0, 4);
         mr = 1'($urandom_range(0, 1));
         mw = 1'($urandom_range(0, 1));
         case (kind)
            0: begin mr = mr; mw = mw; end
            1: begin mr = 0; mw = 0; end
            2: begin mr = 1; mw = 0; end
            3: begin mr = 0; mw = 1; end
            default: begin mr = 1; mw = 1; end
         endcase
         run_entry(kind != 0, mr, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom),
                   $urandom_range(0, 5));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Performs load/store accesses to the data memory over a req/ack handshake.
- Stalls upstream while an access is outstanding.
- Drives the MEM/WB pipeline register (ALU result, load data, rd, WB controls) with bubbles inserted during stalls.

Parameters:
- XLEN, 64, datapath width for address, store data, load data and ALU result.
- MAX_WAIT, 255, maximum BUSY cycles without dmem_ack before the access is aborted (must be ≥1, fits 8-bit counter).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous reset, active-low (reset==0 resets on the next rising clk edge)
- ex_valid  input  1  EX/MEM entry is a real instruction (0 = bubble)
- ex_result  input  XLEN  ALU result; memory address for loads/stores
- ex_writedata  input  XLEN  store data
- ex_rd  input  5  destination register
- ex_memread  input  1  load
- ex_memwrite  input  1  store
- ex_memtoreg  input  1  WB selects load data
- ex_regwrite  input  1  WB writes rd
- mem_stall  output  1  hold PC/IF/ID/IDEX/EXMEM this cycle
- dmem_req  output  1  memory request valid
- dmem_we  output  1  1 = write, 0 = read
- dmem_addr  output  XLEN  request address
- dmem_wdata  output  XLEN  write data
- dmem_ack  input  1  request complete; dmem_rdata valid this cycle
- dmem_rdata  input  XLEN  load data
- wb_valid  output  1  MEM/WB entry valid
- wb_aluresult  output  XLEN  registered ALU result
- wb_readdata  output  XLEN  registered load data
- wb_rd  output  5  registered rd
- wb_memtoreg  output  1  registered memtoreg
- wb_regwrite  output  1  registered regwrite
- mem_timeout  output  1  sticky: an access was aborted by timeout

Behaviour:
- Reset (reset==0 at a clk edge):
  - state→IDLE, wait counter→0.
  - dmem_addr, dmem_wdata, dmem_we→0.
  - All wb_* outputs→0; mem_timeout→0.
  - dmem_req=0 and mem_stall=0 while reset==0.
  - A reset during BUSY abandons the access; dmem_req is low from the edge onward.
- FSM states: IDLE, BUSY. dmem_req = (state==BUSY).
- memop = ex_valid & (ex_memread | ex_memwrite). If both memread and memwrite are set, the entry is treated as a store (dmem_we=1).
- IDLE, ex_valid=0:
  - MEM/WB loads a bubble: wb_valid=0, wb_regwrite=0, other wb_* = 0.
  - mem_stall=0.
- IDLE, ex_valid=1, !memop:
  - MEM/WB loads the entry at the next edge (1-cycle latency): wb_readdata=0, other fields copied.
  - mem_stall=0.
- IDLE, memop:
  - mem_stall=1 (combinational) this cycle.
  - At the edge: latch addr=ex_result, wdata=ex_writedata, we, rd, memtoreg, regwrite; counter→0; state→BUSY.
  - MEM/WB loads a bubble.
- BUSY, dmem_ack=0:
  - mem_stall=1; dmem_req=1 with dmem_addr/dmem_wdata/dmem_we held stable.
  - MEM/WB loads a bubble; counter+1.
  - ex_* inputs are ignored (EX/MEM holds the same entry).
- BUSY, dmem_ack=1:
  - mem_stall=0 this cycle, so EX/MEM advances at this edge.
  - At the edge: MEM/WB loads the latched entry with wb_valid=1. wb_readdata=dmem_rdata for a load, 0 for a store. wb_regwrite/wb_memtoreg are taken from the latched values.
  - state→IDLE.
- Memory-op latency: MEM/WB is written at the first edge where dmem_ack=1 in BUSY. The minimum is 2 edges after the entry is first presented.
- Timeout: BUSY with counter==MAX_WAIT-1 and dmem_ack=0.
  - At the edge: state→IDLE, mem_timeout→1 (sticky until reset), MEM/WB loads a bubble (no regwrite).
  - mem_stall=0 in that cycle.
- dmem_ack in IDLE is ignored.
- Back-to-back memops: after an ack edge, a new memop in IDLE is captured the next cycle. Each access costs ≥2 cycles.
- wb_* are registered only; no combinational path from ex_* or dmem_* to wb_*.

Test Plan:
- Reset low 2 cycles mid-BUSY (addr 0x100) → next cycle dmem_req=0, all wb_*=0, mem_timeout=0, state IDLE.
- ALU op ex_result=0x1234, rd=5, regwrite=1 → next edge wb_valid=1, wb_aluresult=0x1234, wb_rd=5, wb_readdata=0; mem_stall never high.
- Load addr 0x80, rd=7, memtoreg=1, ack after 3 BUSY cycles with rdata=0xDEADBEEF:
  - mem_stall high 4 cycles, dmem_addr=0x80 stable, 4 bubble entries on MEM/WB.
  - Then wb_readdata=0xDEADBEEF, wb_rd=7, wb_regwrite=1.
- Store addr 0x40, wdata=0xA5A5, ack first BUSY cycle → dmem_we=1, dmem_wdata=0xA5A5, wb_valid=1, wb_regwrite=0; a following ALU op reaches MEM/WB the next cycle.
- MAX_WAIT=4, load never acked → dmem_req high exactly 4 cycles, then mem_timeout=1 (stays 1), bubble written, mem_stall released; a later ALU op passes normally.
- Entry with memread=memwrite=1 → dmem_we=1; ex_valid=0 with memread=1 → no request, bubble written.
